// File: rtl/br_pred_pkg.sv
// Shared helpers for the gshare branch predictor: saturating-counter math
// sized by the instantiating module's counter width.
package br_pred_pkg;

  // Wide carrier type so one helper serves every counter width below 32 bits.
  localparam int unsigned SAT_W = 32;
  typedef logic [SAT_W-1:0] sat_t;

  // Largest value a cnt_w-bit counter can hold (all ones).
  function automatic sat_t cnt_max(input int unsigned cnt_w);
    return (sat_t'(1) << cnt_w) - sat_t'(1);
  endfunction

  // One saturating step toward taken (+1) or not-taken (-1); never wraps.
  function automatic sat_t sat_next(input sat_t cnt, input logic taken,
                                    input int unsigned cnt_w);
    sat_t mx;
    mx = cnt_max(cnt_w);
    if (taken) begin
      return (cnt >= mx) ? mx : cnt + sat_t'(1);
    end
    return (cnt == '0) ? '0 : cnt - sat_t'(1);
  endfunction

endpackage

// File: rtl/br_pred_table_if.sv
// Fetch/resolve bus of the branch predictor table. The predictor is the
// slave; fetch plus the resolution stage together act as master.
interface br_pred_table_if #(
  parameter int IDX_W = 4
);

  logic             lookup_vld;
  logic [IDX_W-1:0] lookup_pc;
  logic             pred_vld;
  logic             pred_take;
  logic [IDX_W-1:0] pred_idx;
  logic             upd_vld;
  logic [IDX_W-1:0] upd_idx;
  logic             upd_taken;

  modport master (
    output lookup_vld, lookup_pc, upd_vld, upd_idx, upd_taken,
    input  pred_vld, pred_take, pred_idx
  );

  modport slave (
    input  lookup_vld, lookup_pc, upd_vld, upd_idx, upd_taken,
    output pred_vld, pred_take, pred_idx
  );

endinterface

// File: rtl/br_sat_ctr.sv
// One pattern-history entry: a CNT_W-bit saturating counter that resets to
// strongly taken. The next value is exported so the table can forward it.
module br_sat_ctr
  import br_pred_pkg::*;
#(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc_i,
  input  logic             dec_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic [CNT_W-1:0] cnt_nxt_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(cnt_max(CNT_W));

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next value: one saturating step when enabled, otherwise hold.
  always_comb begin
    cnt_d = cnt_q;
    if (inc_i || dec_i) begin
      cnt_d = CNT_W'(sat_next(sat_t'(cnt_q), inc_i, CNT_W));
    end
  end

  // Counter state, strongly taken out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= CNT_MAX;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o     = cnt_q;
  assign cnt_nxt_o = cnt_d;

endmodule

// File: rtl/br_pred_table.sv
// Gshare branch predictor: 2^IDX_W saturating counters indexed by
// lookup PC XOR global history. Prediction is registered one cycle after
// the lookup; resolution updates both the counter and the history.
module br_pred_table
  import br_pred_pkg::*;
#(
  parameter int IDX_W = 4,
  parameter int CNT_W = 2,
  parameter int GHR_W = 4
) (
  input logic            clk,
  input logic            rst_n,
  br_pred_table_if.slave bus
);

  localparam int DEPTH = 1 << IDX_W;

  typedef logic [IDX_W-1:0] idx_t;
  typedef logic [CNT_W-1:0] cnt_t;

  idx_t ghr_ext;
  idx_t lk_idx;
  logic fwd_hit;
  logic lk_take;

  cnt_t cnt_cur [DEPTH];
  cnt_t cnt_nxt [DEPTH];

  logic pred_vld_q;
  logic pred_vld_d;
  logic pred_take_q;
  logic pred_take_d;
  idx_t pred_idx_q;
  idx_t pred_idx_d;

  // Global history: shifts in resolved outcomes only, so a lookup always
  // sees committed history. With GHR_W = 0 the table is purely bimodal.
  generate
    if (GHR_W > 0) begin : g_ghr
      logic [GHR_W-1:0] ghr_q;
      logic [GHR_W-1:0] ghr_d;

      // Newest outcome enters at the LSB; the oldest falls off the top.
      always_comb begin
        ghr_d = ghr_q;
        if (bus.upd_vld) begin
          ghr_d = GHR_W'({ghr_q, bus.upd_taken});
        end
        ghr_ext = IDX_W'(ghr_q);
      end

      // History register, cleared by reset.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ghr_q <= '0;
        end else begin
          ghr_q <= ghr_d;
        end
      end
    end else begin : g_no_ghr
      assign ghr_ext = '0;
    end
  endgenerate

  // Pattern history table: each entry steps only when addressed by an update.
  generate
    for (genvar i = 0; i < DEPTH; i++) begin : g_ctr
      logic hit;
      assign hit = bus.upd_vld && (bus.upd_idx == idx_t'(i));

      br_sat_ctr #(
        .CNT_W (CNT_W)
      ) u_ctr (
        .clk       (clk),
        .rst_n     (rst_n),
        .inc_i     (hit && bus.upd_taken),
        .dec_i     (hit && !bus.upd_taken),
        .cnt_o     (cnt_cur[i]),
        .cnt_nxt_o (cnt_nxt[i])
      );
    end
  endgenerate

  // Lookup index and direction; a same-cycle update to the same entry is
  // forwarded so the prediction never reflects a stale counter.
  always_comb begin
    lk_idx  = bus.lookup_pc ^ ghr_ext;
    fwd_hit = bus.upd_vld && (bus.upd_idx == lk_idx);
    if (fwd_hit) begin
      lk_take = cnt_nxt[lk_idx][CNT_W-1];
    end else begin
      lk_take = cnt_cur[lk_idx][CNT_W-1];
    end
  end

  // Output stage next state: direction and index hold between lookups.
  always_comb begin
    pred_vld_d  = bus.lookup_vld;
    pred_take_d = pred_take_q;
    pred_idx_d  = pred_idx_q;
    if (bus.lookup_vld) begin
      pred_take_d = lk_take;
      pred_idx_d  = lk_idx;
    end
  end

  // ---- lookup -> prediction boundary ----
  // Output registers; reset drops any in-flight prediction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pred_vld_q  <= 1'b0;
      pred_take_q <= 1'b1;
      pred_idx_q  <= '0;
    end else begin
      pred_vld_q  <= pred_vld_d;
      pred_take_q <= pred_take_d;
      pred_idx_q  <= pred_idx_d;
    end
  end

  assign bus.pred_vld  = pred_vld_q;
  assign bus.pred_take = pred_take_q;
  assign bus.pred_idx  = pred_idx_q;

endmodule
